// File: rtl/queue_pkg.sv
// Shared defaults for the queue FIFO slice: word width, pointer width and derived depth.
package queue_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 64;
  localparam int DEFAULT_ADDRESS_WIDTH = 3;
  localparam int DEPTH                 = 1 << DEFAULT_ADDRESS_WIDTH;

endpackage

// File: rtl/queue_mem.sv
// Register-file storage: one write port, one synchronous read port into the data_out register.
module queue_mem
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     sclk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int ENTRIES = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/queue_fifo.sv
// Single-clock FIFO queue: pointers, occupancy count, accept logic and status flags.
module queue_fifo
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH:0]   count;
  logic                     push;
  logic                     pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A full queue still takes a write when the head leaves on the same edge.
  assign push = write_en && (!full || read_en);
  assign pop  = read_en && !empty;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  queue_mem #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mem (
    .sclk   (sclk),
    .reset  (reset),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (pop),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );

endmodule

// File: tb/tb_queue_fifo.sv
// Bench for queue_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_queue_fifo;

  localparam int DW    = 64;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          sclk     = 1'b0;
  logic          reset    = 1'b0;
  logic          read_en  = 1'b0;
  logic          write_en = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout = '0;

  queue_fifo #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .sclk    (sclk),
    .reset   (reset),
    .read_en (read_en),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, from the queue rules.
  task automatic model_edge(input bit we, input bit re, input logic [DW-1:0] d);
    bit do_pop;
    bit do_push;
    do_pop  = re && (q.size() > 0);
    do_push = we && ((q.size() < DEPTH) || re);
    if (do_pop) m_dout = q.pop_front();
    if (do_push) q.push_back(d);
  endtask

  always @(negedge sclk) begin
    if (check_en) begin
      chk("data_out", data_out, m_dout);
      chk("full", {63'b0, full}, {63'b0, q.size() == DEPTH});
      chk("empty", {63'b0, empty}, {63'b0, q.size() == 0});
    end
  end

  task automatic step(input bit we, input bit re, input logic [DW-1:0] d);
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge sclk);
    if (reset) model_edge(we, re, d);
    @(negedge sclk);
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] vals [4];
    vals[0] = 64'd1; vals[1] = 64'd256; vals[2] = 64'd3325; vals[3] = 64'd0;

    // 1. reset then idle
    #12;
    chk("rst_empty", {63'b0, empty}, 64'd1);
    chk("rst_full", {63'b0, full}, 64'd0);
    chk("rst_dout", data_out, 64'd0);
    @(negedge sclk);
    reset = 1'b1;
    check_en = 1'b1;
    step(0, 0, '0);
    chk("idle_empty", {63'b0, empty}, 64'd1);

    // 2. four pushes, five pops
    for (int i = 0; i < 4; i++) step(1, 0, vals[i]);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, '0);
      chk("t2_pop", data_out, vals[i]);
    end
    chk("t2_empty", {63'b0, empty}, 64'd1);
    step(0, 1, '0);
    chk("t2_pop5", data_out, 64'd0);

    // 3. fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) step(1, 0, 64'(10 + i));
    chk("t3_full", {63'b0, full}, 64'd1);
    step(1, 0, 64'd99);
    chk("t3_full_after_ovf", {63'b0, full}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0);
      chk("t3_pop", data_out, 64'(10 + i));
    end
    chk("t3_empty", {63'b0, empty}, 64'd1);

    // 4. wrap-around
    for (int i = 0; i < 6; i++) step(1, 0, 64'(100 + i));
    for (int i = 0; i < 6; i++) step(0, 1, '0);
    for (int i = 0; i < 8; i++) step(1, 0, 64'(20 + i));
    chk("t4_full", {63'b0, full}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0);
      chk("t4_pop", data_out, 64'(20 + i));
    end

    // 5. simultaneous read+write on full, then on empty
    for (int i = 0; i < 8; i++) step(1, 0, 64'(30 + i));
    step(1, 1, 64'd50);
    chk("t5_full_rw_dout", data_out, 64'd30);
    chk("t5_full_rw_full", {63'b0, full}, 64'd1);
    for (int i = 1; i < 8; i++) begin
      step(0, 1, '0);
      chk("t5_pop", data_out, 64'(30 + i));
    end
    step(0, 1, '0);
    chk("t5_pop_last", data_out, 64'd50);
    step(1, 1, 64'd7);
    chk("t5_empty_rw_dout", data_out, 64'd50);
    chk("t5_empty_rw_empty", {63'b0, empty}, 64'd0);
    step(0, 1, '0);
    chk("t5_pop7", data_out, 64'd7);

    // 6. asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 0, 64'(60 + i));
    step(0, 1, '0);
    chk("t6_pre_dout", data_out, 64'd60);
    @(posedge sclk);
    #2;
    reset = 1'b0;
    q.delete();
    m_dout = '0;
    #1;
    chk("t6_rst_empty", {63'b0, empty}, 64'd1);
    chk("t6_rst_full", {63'b0, full}, 64'd0);
    chk("t6_rst_dout", data_out, 64'd0);
    @(negedge sclk);
    reset = 1'b1;
    step(0, 1, '0);
    chk("t6_pop_ignored", data_out, 64'd0);
    chk("t6_still_empty", {63'b0, empty}, 64'd1);

    // random traffic with write/read bias shifting between phases
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      case ((i / 300) % 3)
        0:       wp = 80;
        1:       wp = 50;
        default: wp = 20;
      endcase
      step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), {$urandom, $urandom});
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
